// File: rtl/cbadc_modulator_fxp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cbadc_modulator_fxp
// Purpose  : Fixed-point chain-of-integrators control-bounded ADC modulator
//            with an input hold stage and saturating integrator states.
// Revision : 1.0
// ============================================================================
module cbadc_modulator_fxp #(
  parameter int M         = 4,
  parameter int DSR       = 6,
  parameter int GainShift = 2,
  parameter int n_int     = 3,
  parameter int n_mant    = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [11:0]  in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [M-1:0] out,
  output logic         valid,
  output logic         ovf
);

  localparam int c_sw = n_int + n_mant + 1;
  localparam int c_ww = c_sw + 2;
  localparam int c_cw = (DSR > 1) ? $clog2(DSR) : 1;
  localparam logic [c_cw-1:0]        c_cnt_last = c_cw'(DSR - 1);
  localparam logic signed [c_ww-1:0] c_kappa    = c_ww'(2 ** (n_mant - GainShift));
  localparam logic signed [c_ww-1:0] c_sat_max  = c_ww'(2 ** (c_sw - 1) - 1);
  localparam logic signed [c_ww-1:0] c_sat_min  = ~c_sat_max;

  logic                   r_accepted;
  logic                   r_starved;
  logic [c_cw-1:0]        r_cnt;
  logic [11:0]            r_hold;
  logic signed [c_sw-1:0] r_x [M];

  logic                   w_transfer;
  logic signed [11:0]     w_u12;
  logic signed [c_sw-1:0] w_u;
  logic signed [c_sw-1:0] w_next [M];
  logic [M-1:0]           w_s;
  logic [M-1:0]           w_clamp;

  // Starved: reload slot passed without a sample, keep offering ready.
  assign in_ready   = !r_accepted || r_starved || (r_cnt == c_cnt_last);
  assign w_transfer = in_valid && in_ready;

  // Offset binary -> signed Q0.11, left-aligned into the state format.
  assign w_u12 = {~r_hold[11], r_hold[10:0]};
  assign w_u   = c_sw'(w_u12) <<< (n_mant - 11);

  always_comb begin
    w_s = '0;
    for (int k = 0; k < M; k++) begin
      w_s[k] = ~r_x[k][c_sw-1];
    end
  end

  for (genvar k = 0; k < M; k++) begin : g_stage
    logic signed [c_sw-1:0] w_v;
    logic signed [c_ww-1:0] w_sum;
    logic                   w_hi;
    logic                   w_lo;

    if (k == 0) begin : g_first
      assign w_v = w_u;
    end else begin : g_chain
      assign w_v = r_x[k-1];
    end

    assign w_sum = c_ww'(r_x[k]) + c_ww'(w_v >>> GainShift)
                 + (w_s[k] ? -c_kappa : c_kappa);
    assign w_hi  = (w_sum > c_sat_max);
    assign w_lo  = (w_sum < c_sat_min);
    assign w_next[k]  = w_hi ? c_sat_max[c_sw-1:0] :
                        w_lo ? c_sat_min[c_sw-1:0] : w_sum[c_sw-1:0];
    assign w_clamp[k] = w_hi || w_lo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_accepted <= 1'b0;
      r_starved  <= 1'b0;
      r_cnt      <= '0;
      r_hold     <= 12'h800;
      out        <= '0;
      valid      <= 1'b0;
      ovf        <= 1'b0;
      for (int k = 0; k < M; k++) begin
        r_x[k] <= '0;
      end
    end else begin
      out   <= w_s;
      valid <= valid || r_accepted;
      if (w_transfer) begin
        r_hold     <= in;
        r_accepted <= 1'b1;
        r_starved  <= 1'b0;
        r_cnt      <= '0;
      end else if (r_accepted) begin
        r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
        if (in_ready) begin
          r_starved <= 1'b1;
        end
      end
      if (r_accepted) begin
        for (int k = 0; k < M; k++) begin
          r_x[k] <= w_next[k];
        end
        ovf <= ovf || (|w_clamp);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cbadc_modulator_fxp.md
CBADC_MODULATOR_FXP -- requirements
Module: cbadc_modulator_fxp

Interface
REQ-001 Parameter M, default 4: number of integrator stages and width of the control-bit output.
REQ-002 Parameter DSR, default 6: clk cycles each accepted input sample is held (DSR >= 1).
REQ-003 Parameter GainShift, default 2: integrator gain, 2^-GainShift, applied as an arithmetic right shift.
REQ-004 Parameter n_int, default 3: integer bits of the integrator state.
REQ-005 Parameter n_mant, default 14: fractional bits of the integrator state; state width is n_int+n_mant+1, signed.
REQ-006 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  Reset, asynchronous, active-low.
REQ-008 in  input  12  Input sample, offset binary: 0x000 = -1.0, 0x800 = 0.0, 0xFFF = +1-2^-11.
REQ-009 in_valid  input  1  Input sample on `in` is valid.
REQ-010 in_ready  output  1  Block accepts `in` this cycle.
REQ-011 out  output  M  Control bits; out[k] belongs to stage k and is 1 when x_k >= 0.
REQ-012 valid  output  1  `out` carries modulator decisions for real input.
REQ-013 ovf  output  1  Sticky flag: an integrator saturated.

Function
REQ-014 Acceptance: a transfer occurs on a rising edge where in_valid=1 and in_ready=1; `in` is then latched into the hold register.
REQ-015 Hold counter: counts 0..DSR-1 and wraps; it restarts at 0 on each transfer.
REQ-016 in_ready: is 1 when no sample has been accepted since reset, or when the hold counter = DSR-1; it is 0 otherwise; with DSR=1 it is constantly 1.
REQ-017 Missed reload: if in_ready=1 and in_valid=0, the held sample is retained, the counter wraps, and in_ready stays 1 until a transfer.
REQ-018 Conversion: u = held sample with its MSB inverted, read as signed Q0.11, sign-extended and left-aligned into the Q(n_int).(n_mant) state format.
REQ-019 Bits: s_k = NOT sign(x_k), computed from the current state.
REQ-020 Feedback: kappa = 2^-GainShift; f_k = -kappa when s_k=1, f_k = +kappa when s_k=0.
REQ-021 Stage input: v_0 = u; v_k = x_{k-1} for k > 0, using the pre-update value.
REQ-022 Update: every clk cycle after the first transfer, x_k <= sat(x_k + (v_k >>> GainShift) + f_k) for all k simultaneously.
REQ-023 Update width: the sum is formed two bits wider than the state, then clamped to [-2^n_int, 2^n_int - 2^-n_mant].
REQ-024 Saturation: any clamp sets ovf, which stays 1 until reset.
REQ-025 Output: out <= s (the vector of s_k) every cycle, i.e. a one-cycle register latency from state to out.
REQ-026 valid: is set one cycle after the first transfer and stays 1 until reset.
REQ-027 Pre-start: before the first transfer the integrators hold 0, out = all-ones, and valid = 0.
REQ-028 Arithmetic: all arithmetic is two's complement; no rounding beyond the truncation of the right shift.

Reset
REQ-029 While rst=0: x_k=0, out=0, valid=0, ovf=0, hold counter=0, hold register=0x800, and the "accepted" flag is cleared.
REQ-030 Reset asserted mid-operation clears all state immediately, with no wait for a clk edge.
REQ-031 After rst deasserts, in_ready=1 combinationally; the first transfer may occur on the first edge.
REQ-032 Reset deassertion is synchronous to clk in the surrounding system; the block adds no synchronizer.

Verification
REQ-033 Defaults; rst release; in=0x800 held valid -> out[0] toggles 1,0,1,0 each cycle; valid=1 from cycle 2; ovf=0 throughout.
REQ-034 DSR=6; in_valid tied high -> in_ready pulses high one cycle in every 6; exactly one transfer per 6 clk cycles; `in` changes while in_ready=0 are ignored.
REQ-035 DSR=6; in_valid dropped at a reload -> the held value persists, in_ready stays 1, and the next in_valid=1 is accepted on that edge with the counter at 0.
REQ-036 in=0xFFF held for 1000 cycles -> mean of out[0] lies in 0.999 +/- 0.01 and ovf=0; the same run with GainShift=0 and n_int=0 -> ovf=1 and stays 1.
REQ-037 rst asserted mid-stream between clk edges -> out=0, valid=0, and in_ready=1 before the next edge; after release, behaviour is identical to REQ-033.
REQ-038 Loopback: 12-bit sine at 1/64 of the input rate into this block with M and DSR matching FIR_Staggered_Fxp, feeding that filter -> filter output tracks the input with SNR >= 50 dB after its valid asserts.
